// File: rtl/alu_exec_unit_pkg.sv
// Shared encodings for the MIPS execute-stage ALU.
// ALU control codes, ALUop values and R-type funct codes.
package alu_exec_unit_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

endpackage

// File: rtl/alu_exec_unit_adder32.sv
// 32-bit adder with carry-in and carry-out.
// Shared by the ALU add/sub path and the branch target path.
module alu_adder32 #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_cin,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_cout
);

  logic [DATA_W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b}
                + {{DATA_W{1'b0}}, i_cin};
  assign o_sum  = w_full[DATA_W-1:0];
  assign o_cout = w_full[DATA_W];

endmodule

// File: rtl/alu_exec_unit.sv
// MIPS execute stage: ALU control decode, ALU, branch target.
// All outputs registered, one cycle of latency.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        alu_op,
  input  logic              alu_src,
  input  logic [DATA_W-1:0] reg_data1,
  input  logic [DATA_W-1:0] reg_data2,
  input  logic [DATA_W-1:0] sign_ext_imm,
  input  logic [DATA_W-1:0] incremented_pc,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero,
  output logic              overflow,
  output logic [DATA_W-1:0] branch_address,
  output logic [2:0]        alu_ctrl
);

  logic [2:0]        w_ctrl;
  logic [5:0]        w_funct;
  logic [DATA_W-1:0] w_b;
  logic              w_sub;
  logic [DATA_W-1:0] w_b_add;
  logic [DATA_W-1:0] w_sum;
  logic              w_alu_cout;
  logic [DATA_W-1:0] w_off;
  logic [DATA_W-1:0] w_br;
  logic              w_br_cout;
  logic              w_slt;
  logic [DATA_W-1:0] w_res;
  logic              w_ovf;

  logic [DATA_W-1:0] r_result;
  logic              r_zero;
  logic              r_ovf;
  logic [DATA_W-1:0] r_br;
  logic [2:0]        r_ctrl;

  assign w_funct = sign_ext_imm[5:0];

  always_comb begin
    w_ctrl = ALU_ADD;
    unique case (alu_op)
      ALUOP_ADD: w_ctrl = ALU_ADD;
      ALUOP_SUB: w_ctrl = ALU_SUB;
      ALUOP_OR:  w_ctrl = ALU_OR;
      ALUOP_RTYPE: begin
        case (w_funct)
          FUNCT_ADD: w_ctrl = ALU_ADD;
          FUNCT_SUB: w_ctrl = ALU_SUB;
          FUNCT_AND: w_ctrl = ALU_AND;
          FUNCT_OR:  w_ctrl = ALU_OR;
          FUNCT_SLT: w_ctrl = ALU_SLT;
          FUNCT_NOR: w_ctrl = ALU_NOR;
          default:   w_ctrl = ALU_ADD;
        endcase
      end
    endcase
  end

  assign w_b     = alu_src ? sign_ext_imm : reg_data2;
  assign w_sub   = (w_ctrl == ALU_SUB);
  assign w_b_add = w_b ^ {DATA_W{w_sub}};

  alu_adder32 #(.DATA_W(DATA_W)) u_alu_add (
    .i_a   (reg_data1),
    .i_b   (w_b_add),
    .i_cin (w_sub),
    .o_sum (w_sum),
    .o_cout(w_alu_cout)
  );

  assign w_off = sign_ext_imm << BR_SHIFT;

  alu_adder32 #(.DATA_W(DATA_W)) u_br_add (
    .i_a   (incremented_pc),
    .i_b   (w_off),
    .i_cin (1'b0),
    .o_sum (w_br),
    .o_cout(w_br_cout)
  );

  // Carry-outs are not architecturally visible.
  logic w_unused;
  assign w_unused = &{1'b0, w_alu_cout, w_br_cout};

  // Direct signed compare stays correct when A-B overflows.
  assign w_slt = $signed(reg_data1) < $signed(w_b);

  always_comb begin
    w_res = '0;
    case (w_ctrl)
      ALU_AND: w_res = reg_data1 & w_b;
      ALU_OR:  w_res = reg_data1 | w_b;
      ALU_NOR: w_res = ~(reg_data1 | w_b);
      ALU_ADD: w_res = w_sum;
      ALU_SUB: w_res = w_sum;
      ALU_SLT: w_res = {{(DATA_W-1){1'b0}}, w_slt};
      default: w_res = '0;
    endcase
  end

  // Effective B is already inverted for SUB, so one rule covers both.
  assign w_ovf = (w_ctrl == ALU_ADD || w_sub)
               && (reg_data1[DATA_W-1] == w_b_add[DATA_W-1])
               && (w_sum[DATA_W-1] != reg_data1[DATA_W-1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_br     <= '0;
      r_ctrl   <= '0;
    end else begin
      r_result <= w_res;
      r_zero   <= (w_res == '0);
      r_ovf    <= w_ovf;
      r_br     <= w_br;
      r_ctrl   <= w_ctrl;
    end
  end

  assign alu_result     = r_result;
  assign zero           = r_zero;
  assign overflow       = r_ovf;
  assign branch_address = r_br;
  assign alu_ctrl       = r_ctrl;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed vector bench for alu_exec_unit.
// Table of hand-computed vectors plus reset sequences.
module tb_alu_exec_unit;

  logic        clk;
  logic        reset;
  logic [1:0]  alu_op;
  logic        alu_src;
  logic [31:0] reg_data1;
  logic [31:0] reg_data2;
  logic [31:0] sign_ext_imm;
  logic [31:0] incremented_pc;
  logic [31:0] alu_result;
  logic        zero;
  logic        overflow;
  logic [31:0] branch_address;
  logic [2:0]  alu_ctrl;

  int n_vec;
  int n_bad;

  typedef struct {
    logic [1:0]  op;
    logic        src;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] res;
    logic        z;
    logic        ov;
    logic [2:0]  ctrl;
    logic [31:0] br;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  alu_exec_unit dut (
    .clk           (clk),
    .reset         (reset),
    .alu_op        (alu_op),
    .alu_src       (alu_src),
    .reg_data1     (reg_data1),
    .reg_data2     (reg_data2),
    .sign_ext_imm  (sign_ext_imm),
    .incremented_pc(incremented_pc),
    .alu_result    (alu_result),
    .zero          (zero),
    .overflow      (overflow),
    .branch_address(branch_address),
    .alu_ctrl      (alu_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input vec_t v);
    alu_op         = v.op;
    alu_src        = v.src;
    reg_data1      = v.a;
    reg_data2      = v.b;
    sign_ext_imm   = v.imm;
    incremented_pc = v.pc;
  endtask

  task automatic check(input string name, input logic [31:0] res,
                       input logic z, input logic ov,
                       input logic [2:0] ctrl, input logic [31:0] br);
    n_vec++;
    if (alu_result !== res || zero !== z || overflow !== ov
        || alu_ctrl !== ctrl || branch_address !== br) begin
      n_bad++;
      $display("FAIL %s: got res=%h z=%b ov=%b ctrl=%b br=%h, want res=%h z=%b ov=%b ctrl=%b br=%h",
               name, alu_result, zero, overflow, alu_ctrl, branch_address,
               res, z, ov, ctrl, br);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;

    vecs[0]  = '{2'b00, 1'b0, 32'd5, 32'd7, 32'h0, 32'h0,
                 32'd12, 1'b0, 1'b0, 3'b010, 32'h0};
    vecs[1]  = '{2'b10, 1'b0, 32'hF0F0_0000, 32'h0FF0_0000, 32'h24, 32'h0,
                 32'h00F0_0000, 1'b0, 1'b0, 3'b000, 32'h90};
    vecs[2]  = '{2'b10, 1'b0, 32'hF0F0_0000, 32'h0FF0_0000, 32'h25, 32'h0,
                 32'hFFF0_0000, 1'b0, 1'b0, 3'b001, 32'h94};
    vecs[3]  = '{2'b10, 1'b0, 32'hF0F0_0000, 32'h0FF0_0000, 32'h27, 32'h0,
                 32'h000F_FFFF, 1'b0, 1'b0, 3'b100, 32'h9C};
    vecs[4]  = '{2'b10, 1'b0, 32'hF0F0_0000, 32'h0FF0_0000, 32'h22, 32'h0,
                 32'hE100_0000, 1'b0, 1'b0, 3'b110, 32'h88};
    vecs[5]  = '{2'b10, 1'b0, 32'hF0F0_0000, 32'h0FF0_0000, 32'h00, 32'h0,
                 32'h00E0_0000, 1'b0, 1'b0, 3'b010, 32'h0};
    vecs[6]  = '{2'b01, 1'b0, 32'h1234, 32'h1234, 32'h0, 32'h0,
                 32'h0, 1'b1, 1'b0, 3'b110, 32'h0};
    vecs[7]  = '{2'b01, 1'b0, 32'd1, 32'd2, 32'h0, 32'h0,
                 32'hFFFF_FFFF, 1'b0, 1'b0, 3'b110, 32'h0};
    vecs[8]  = '{2'b10, 1'b0, 32'h8000_0000, 32'd1, 32'h2A, 32'h0,
                 32'd1, 1'b0, 1'b0, 3'b111, 32'hA8};
    vecs[9]  = '{2'b10, 1'b0, 32'd5, 32'd3, 32'h2A, 32'h0,
                 32'd0, 1'b1, 1'b0, 3'b111, 32'hA8};
    vecs[10] = '{2'b10, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'h20, 32'h0,
                 32'h8000_0000, 1'b0, 1'b1, 3'b010, 32'h80};
    vecs[11] = '{2'b10, 1'b0, 32'h8000_0000, 32'd1, 32'h22, 32'h0,
                 32'h7FFF_FFFF, 1'b0, 1'b1, 3'b110, 32'h88};
    vecs[12] = '{2'b00, 1'b1, 32'd100, 32'd9, 32'hFFFF_FFFC, 32'd44,
                 32'd96, 1'b0, 1'b0, 3'b010, 32'd28};
    vecs[13] = '{2'b11, 1'b1, 32'h10, 32'h0, 32'h0000_000F, 32'h0,
                 32'h1F, 1'b0, 1'b0, 3'b001, 32'h3C};
    vecs[14] = '{2'b00, 1'b0, 32'h0, 32'h0, 32'd2, 32'hFFFF_FFFC,
                 32'h0, 1'b1, 1'b0, 3'b010, 32'h4};

    reset          = 1'b1;
    alu_op         = 2'b10;
    alu_src        = 1'b1;
    reg_data1      = 32'hDEAD_BEEF;
    reg_data2      = 32'h1234_5678;
    sign_ext_imm   = 32'hFFFF_FF25;
    incremented_pc = 32'h0040_0000;
    tick();
    check("reset_edge1", 32'h0, 1'b0, 1'b0, 3'b000, 32'h0);
    reg_data1 = 32'h0;
    tick();
    check("reset_edge2", 32'h0, 1'b0, 1'b0, 3'b000, 32'h0);

    reset = 1'b0;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      tick();
      check($sformatf("vec%0d", i), vecs[i].res, vecs[i].z,
            vecs[i].ov, vecs[i].ctrl, vecs[i].br);
    end

    // Mid-stream reset: one cycle of zeros, then resume.
    drive(vecs[12]);
    tick();
    check("pre_reset", vecs[12].res, vecs[12].z, vecs[12].ov,
          vecs[12].ctrl, vecs[12].br);
    reset = 1'b1;
    drive(vecs[14]);
    tick();
    check("mid_reset", 32'h0, 1'b0, 1'b0, 3'b000, 32'h0);
    reset = 1'b0;
    drive(vecs[10]);
    tick();
    check("post_reset", vecs[10].res, vecs[10].z, vecs[10].ov,
          vecs[10].ctrl, vecs[10].br);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage arithmetic core of the 5-stage MIPS pipeline, sitting between the ID/EX and EX/MEM registers.
- Decodes ALUop plus the funct field into a 3-bit ALU operation and selects the second operand (register or sign-extended immediate).
- Computes the 32-bit ALU result and zero flag, and the branch target (incremented PC + offset<<2).
- All outputs are registered with one cycle of latency.

Parameters:
- DATA_W, 32, datapath width. Only 32 is supported; it is kept as a parameter for readability.
- BR_SHIFT, 2, left shift applied to the sign-extended offset for the branch target.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- alu_op  input  2  ALUop from main control (ID_EX EX field bits [3:2])
- alu_src  input  1  1 = operand B is sign_ext_imm; 0 = operand B is reg_data2
- reg_data1  input  32  operand A (rs value)
- reg_data2  input  32  register operand B (rt value)
- sign_ext_imm  input  32  sign-extended 16-bit immediate; bits [5:0] are the funct field
- incremented_pc  input  32  PC+4 of the instruction
- alu_result  output  32  registered ALU result
- zero  output  1  registered; 1 when the ALU result is all zeros
- overflow  output  1  registered signed overflow for ADD/SUB, else 0 (status only, no trap)
- branch_address  output  32  registered incremented_pc + (sign_ext_imm << 2), modulo 2^32
- alu_ctrl  output  3  registered decoded ALU operation (debug/visibility)

Behaviour:
- Reset: on a rising edge with reset=1, all outputs are 0, including zero=0. Reset has priority over the datapath.
- Latency: inputs are sampled on a rising edge, and outputs reflect them after that edge (1 cycle). There is no handshake; the unit accepts new operands every cycle.
- ALU control decode (combinational, then registered along with the result):
  - alu_op=00 → ADD (010), used by lw/sw.
  - alu_op=01 → SUB (110), used by beq.
  - alu_op=11 → OR (001), used by ori.
  - alu_op=10 → decode funct = sign_ext_imm[5:0]:
    - 100000 → ADD 010
    - 100010 → SUB 110
    - 100100 → AND 000
    - 100101 → OR 001
    - 101010 → SLT 111
    - 100111 → NOR 100
    - any other funct → ADD 010
- Operand B = alu_src ? sign_ext_imm : reg_data2.
- ALU operations:
  - AND, OR and NOR are bitwise.
  - ADD and SUB wrap modulo 2^32.
  - SLT: result = 1 if A < B as signed 32-bit values, else 0. It is computed by direct signed compare, not from the sign of the difference, so it stays correct when the subtraction overflows.
  - Undefined ctrl codes (011, 101) produce result 0.
- zero = (result == 0), evaluated on the same-cycle result; it is valid for every operation.
- overflow:
  - ADD: 1 when A and B have equal signs and the result sign differs.
  - SUB: 1 when A and B have differing signs and the result sign differs from A.
  - Otherwise 0.
- Branch adder: computed every cycle, independent of alu_op. The shift discards the upper 2 bits of sign_ext_imm, and the add wraps.
- Reset asserted mid-stream: the outputs of that cycle are 0, and operation resumes on the next edge with reset=0. No state other than the output registers exists.

Decomposition:
- Shared package holds:
  - ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_NOR=3'b100, ALU_SUB=3'b110, ALU_SLT=3'b111
  - ALUOP_* encodings
  - FUNCT_* constants
- One natural sub-module: alu_adder32, a 32-bit adder with carry-in and carry-out. It is instantiated twice: once in the ALU for ADD/SUB (SUB uses inverted B with carry-in 1) and once for the branch target.
- Control decode and the operand mux stay inline.

Test Plan:
- Reset: hold reset=1 with arbitrary inputs for 2 edges → all outputs 0, zero=0. Deassert with alu_op=00, A=5, B(reg)=7, alu_src=0 → next edge alu_result=12, zero=0, alu_ctrl=010.
- R-type sweep (alu_op=10), A=0xF0F0_0000, B=0x0FF0_0000:
  - AND → 0x00F0_0000
  - OR → 0xFFF0_0000
  - NOR → 0x000F_FFFF
  - SUB → 0xE100_0000
  - unknown funct 000000 → ADD 0x00E0_0000
- beq (alu_op=01): A=B=0x1234 → result 0, zero=1. Then A=1, B=2 → result 0xFFFF_FFFF, zero=0.
- SLT/overflow:
  - A=0x8000_0000, B=1, SLT → 1.
  - A=0x7FFF_FFFF, B=1, ADD → 0x8000_0000, overflow=1.
  - A=0x8000_0000, B=1, SUB → 0x7FFF_FFFF, overflow=1.
- Immediate and branch: alu_src=1, alu_op=00, A=100, sign_ext_imm=0xFFFF_FFFC → result 96. Same cycle, incremented_pc=44 → branch_address=28.
- Branch wrap: incremented_pc=0xFFFF_FFFC, imm=2 → branch_address=0x0000_0004. Assert reset mid-sequence → outputs 0 for that cycle only.
